// File: rtl/spiflash_mem_if.sv
// spiflash_mem_if: littlecpu memory handshake towards the flash controller.
// The CPU side is the master; the flash controller is the slave.
interface spiflash_mem_if;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        mem_err;

   modport master (
      output mem_valid, mem_addr, mem_wstrb,
      input  mem_ready, mem_rdata, mem_err
   );

   modport slave (
      input  mem_valid, mem_addr, mem_wstrb,
      output mem_ready, mem_rdata, mem_err
   );
endinterface

// File: rtl/spiflash_mem.sv
// spiflash_mem: SPI/QSPI NOR-flash read controller on the littlecpu bus.
// Each 32-bit read becomes one complete flash read; writes are rejected.
module spiflash_mem #(
   parameter int CLK_DIV      = 1,
   parameter bit QUAD         = 1'b0,
   parameter int DUMMY_CYCLES = 8,
   parameter int ADDR_BITS    = 24
) (
   input  logic          clk,
   input  logic          reset,
   spiflash_mem_if.slave bus,
   output logic          flash_cs,
   output logic          flash_clk,
   output logic [3:0]    flash_io_out,
   output logic [3:0]    flash_io_oe,
   input  logic [3:0]    flash_io_in
);
   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, GAP} state_t;

   localparam logic [7:0] CMD_BYTE  = QUAD ? 8'h6B : 8'h03;
   localparam logic [8:0] HALF_END  = 9'(CLK_DIV - 1);
   localparam logic [8:0] GAP_END   = 9'(2 * CLK_DIV - 1);
   localparam logic [5:0] ADDR_END  = 6'(ADDR_BITS - 1);
   localparam logic [5:0] DUMMY_END = 6'(DUMMY_CYCLES - 1);
   localparam logic [5:0] DATA_END  = QUAD ? 6'd7 : 6'd31;
   localparam bit         HAS_DUMMY = QUAD && (DUMMY_CYCLES > 0);

   state_t      state, state_n;
   logic [8:0]  cnt, cnt_n;
   logic [5:0]  bits, bits_n;
   logic [31:0] sh, sh_n;
   logic [31:0] rx, rx_n;
   logic        cs, cs_n;
   logic        sclk, sclk_n;
   logic [3:0]  out, out_n;
   logic [3:0]  oe, oe_n;
   logic        ready, ready_n;
   logic        err, err_n;
   logic [31:0] rdata, rdata_n;
   logic        half, fall;
   logic [5:0]  last;
   logic        unused_bits;

   assign unused_bits   = ^{bus.mem_addr[31:24], bus.mem_addr[1:0]};
   assign bus.mem_ready = ready;
   assign bus.mem_err   = err;
   assign bus.mem_rdata = rdata;
   assign flash_cs      = cs;
   assign flash_clk     = sclk;
   assign flash_io_out  = out;
   assign flash_io_oe   = oe;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         bits  <= '0;
         sh    <= '0;
         rx    <= '0;
         cs    <= 1'b1;
         sclk  <= 1'b0;
         out   <= 4'b1100;
         oe    <= 4'b1101;
         ready <= 1'b0;
         err   <= 1'b0;
         rdata <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         bits  <= bits_n;
         sh    <= sh_n;
         rx    <= rx_n;
         cs    <= cs_n;
         sclk  <= sclk_n;
         out   <= out_n;
         oe    <= oe_n;
         ready <= ready_n;
         err   <= err_n;
         rdata <= rdata_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      bits_n  = bits;
      sh_n    = sh;
      rx_n    = rx;
      cs_n    = cs;
      sclk_n  = sclk;
      out_n   = out;
      oe_n    = oe;
      ready_n = 1'b0;
      err_n   = 1'b0;
      rdata_n = rdata;
      half    = (cnt == HALF_END);
      fall    = half && sclk;

      unique case (state)
         CMD:     last = 6'd7;
         ADDR:    last = ADDR_END;
         DUMMY:   last = DUMMY_END;
         default: last = DATA_END;
      endcase

      unique case (state)
         IDLE: begin
            // the cycle showing mem_ready still has the old request on the bus
            if (bus.mem_valid && !ready) begin
               if (bus.mem_wstrb != 4'b0) begin
                  ready_n = 1'b1;
                  err_n   = 1'b1;
               end else begin
                  state_n = CMD;
                  cnt_n   = '0;
                  bits_n  = '0;
                  sh_n    = {CMD_BYTE, bus.mem_addr[23:2], 2'b00};
                  cs_n    = 1'b0;
                  sclk_n  = 1'b0;
                  out_n   = {3'b110, CMD_BYTE[7]};
               end
            end
         end
         CMD, ADDR, DUMMY, DATA: begin
            cnt_n = half ? 9'd0 : cnt + 9'd1;
            if (half) sclk_n = !sclk;
            if (fall) begin
               bits_n   = bits + 6'd1;
               sh_n     = sh << 1;
               out_n[0] = sh[30];
               if (state == DATA)
                  rx_n = QUAD ? {rx[27:0], flash_io_in}
                              : {rx[30:0], flash_io_in[1]};
               if (bits == last) begin
                  bits_n = '0;
                  unique case (state)
                     CMD: state_n = ADDR;
                     ADDR: begin
                        state_n = HAS_DUMMY ? DUMMY : DATA;
                        oe_n    = 4'b0000;
                     end
                     DUMMY: state_n = DATA;
                     default: begin
                        state_n = GAP;
                        cnt_n   = '0;
                        cs_n    = 1'b1;
                        out_n   = 4'b1100;
                        oe_n    = 4'b1101;
                        ready_n = 1'b1;
                        rdata_n = {rx_n[7:0], rx_n[15:8],
                                   rx_n[23:16], rx_n[31:24]};
                     end
                  endcase
               end
            end
         end
         GAP: begin
            cnt_n = cnt + 9'd1;
            if (cnt == GAP_END) begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         end
         default: state_n = IDLE;
      endcase
   end
endmodule
